// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the divider flow-control wrapper
// Contents:
//   DEF_DATAWIDTH : default operand/result width
//   div_result_t  : one stored result, packed as {dz, q, r}
//   ptr_width()   : FIFO pointer / credit counter width (index bits + wrap bit)
package div_pkg;

  localparam int DEF_DATAWIDTH = 8;

  typedef struct packed {
    logic                     dz;
    logic [DEF_DATAWIDTH-1:0] q;
    logic [DEF_DATAWIDTH-1:0] r;
  } div_result_t;

  // One extra bit above the index lets both "empty" and "full" (and a
  // credit count of exactly DEPTH) be represented without ambiguity.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/div_result_fifo.sv
// rtl/div_result_fifo.sv - first-word-fall-through result FIFO
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push_i, wdata_i   : write strobe and entry (ignored when full)
//   pop_i             : consume head entry (ignored when empty)
//   rdata_o           : head entry, zero when empty
//   full_o, empty_o   : status
module div_result_fifo
  import div_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Masked to zero so downstream never sees stale data while invalid.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[IW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[IW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/div_flow_ctrl.sv
// rtl/div_flow_ctrl.sv - valid/ready flow-control wrapper around a fixed-latency array divider
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   s_valid/s_ready/s_a/s_b        : request slave port (dividend, divisor)
//   div_i_valid/div_a/div_b        : to divider inputs
//   div_o_valid/div_q/div_r        : from divider outputs
//   m_valid/m_ready/m_q/m_r/m_dz   : result master port with divide-by-zero flag
//   occupancy                      : outstanding credits (in flight + stored)
//   err                            : sticky protocol error
module div_flow_ctrl
  import div_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int LATENCY   = 9,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATAWIDTH-1:0]          s_a,
  input  logic [DATAWIDTH-1:0]          s_b,
  output logic                          div_i_valid,
  output logic [DATAWIDTH-1:0]          div_a,
  output logic [DATAWIDTH-1:0]          div_b,
  input  logic                          div_o_valid,
  input  logic [DATAWIDTH-1:0]          div_q,
  input  logic [DATAWIDTH-1:0]          div_r,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATAWIDTH-1:0]          m_q,
  output logic [DATAWIDTH-1:0]          m_r,
  output logic                          m_dz,
  output logic [ptr_width(DEPTH)-1:0]   occupancy,
  output logic                          err
);

  localparam int            CW      = ptr_width(DEPTH);
  localparam int            EW      = 2 * DATAWIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]      credits_q, credits_d;
  logic [LATENCY-1:0] exp_v_q, exp_v_d;
  logic [LATENCY-1:0] dz_q, dz_d;
  logic               err_q, err_d;
  logic               issue, pop, exp_tap, dz_tap;
  logic               fifo_full, fifo_empty;
  logic [EW-1:0]      wentry, rentry;

  // Registered-only ready: the divider cannot stall, so a request is only
  // taken when a FIFO slot is already reserved for its result.
  assign s_ready     = (credits_q < DEPTH_C);
  assign issue       = s_valid & s_ready;
  assign div_i_valid = issue;
  assign div_a       = s_a;
  assign div_b       = s_b;

  assign m_valid   = ~fifo_empty;
  assign pop       = m_valid & m_ready;
  assign exp_tap   = exp_v_q[LATENCY-1];
  assign dz_tap    = dz_q[LATENCY-1];
  assign occupancy = credits_q;
  assign err       = err_q;

  // Divide-by-zero results are normalised so the divider's own output for
  // that case never leaks out.
  assign wentry = dz_tap ? {1'b1, {DATAWIDTH{1'b1}}, {DATAWIDTH{1'b0}}}
                         : {1'b0, div_q, div_r};

  assign m_dz = rentry[EW-1];
  assign m_q  = rentry[2*DATAWIDTH-1:DATAWIDTH];
  assign m_r  = rentry[DATAWIDTH-1:0];

  always_comb begin
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   if (credits_q != '0) credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
    // Shift in at bit 0; the truncating cast also covers LATENCY == 1.
    exp_v_d = LATENCY'({exp_v_q, issue});
    dz_d    = LATENCY'({dz_q, issue & (s_b == '0)});
    err_d   = err_q
            | (div_o_valid != exp_tap)
            | (div_o_valid & fifo_full)
            | (pop & (credits_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= '0;
      exp_v_q   <= '0;
      dz_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      exp_v_q   <= exp_v_d;
      dz_q      <= dz_d;
      err_q     <= err_d;
    end
  end

  div_result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (div_o_valid),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (rentry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_div_flow_ctrl.sv
// tb/tb_div_flow_ctrl.sv - self-checking bench for div_flow_ctrl with a behavioural divider
module tb_div_flow_ctrl;

  localparam int DW      = 8;
  localparam int LATENCY = 9;
  localparam int DEPTH   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_a, s_b;
  logic          div_i_valid;
  logic [DW-1:0] div_a, div_b;
  logic          div_o_valid;
  logic [DW-1:0] div_q, div_r;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_q, m_r;
  logic          m_dz;
  logic [2:0]    occupancy;
  logic          err;
  logic          force_ov;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_flow_ctrl #(.DATAWIDTH(DW), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .div_i_valid(div_i_valid), .div_a(div_a), .div_b(div_b),
    .div_o_valid(div_o_valid), .div_q(div_q), .div_r(div_r),
    .m_valid(m_valid), .m_ready(m_ready), .m_q(m_q), .m_r(m_r), .m_dz(m_dz),
    .occupancy(occupancy), .err(err)
  );

  // Behavioural fixed-latency divider, reset with the wrapper.
  logic          dv_v [LATENCY];
  logic [DW-1:0] dv_a [LATENCY];
  logic [DW-1:0] dv_b [LATENCY];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        dv_v[i] <= 1'b0; dv_a[i] <= '0; dv_b[i] <= '0;
      end
    end else begin
      dv_v[0] <= div_i_valid; dv_a[0] <= div_a; dv_b[0] <= div_b;
      for (int i = 1; i < LATENCY; i++) begin
        dv_v[i] <= dv_v[i-1]; dv_a[i] <= dv_a[i-1]; dv_b[i] <= dv_b[i-1];
      end
    end
  end

  // For b==0 the divider emits junk the wrapper must override.
  assign div_o_valid = dv_v[LATENCY-1] | force_ov;
  assign div_q = (dv_b[LATENCY-1] == 0) ? 8'h00 : dv_a[LATENCY-1] / dv_b[LATENCY-1];
  assign div_r = (dv_b[LATENCY-1] == 0) ? dv_a[LATENCY-1] : dv_a[LATENCY-1] % dv_b[LATENCY-1];

  // Reference model: each accepted request becomes visible LATENCY+1 cycles
  // after acceptance, in order; credits = accepted minus consumed.
  typedef struct {
    int            avail;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t mq[$];
  int   cred = 0;
  int   cyc  = 0;
  logic exp_sr, exp_mv;
  exp_t front;

  task automatic predict();
    @(negedge clk);
    exp_sr = (cred < DEPTH);
    exp_mv = (mq.size() > 0) && (mq[0].avail <= cyc);
    if (exp_mv) front = mq[0];
  endtask

  task automatic adv();
    exp_t e;
    bit   iss, pp;
    iss = s_valid && exp_sr;
    pp  = exp_mv && m_ready;
    if (pp) begin
      void'(mq.pop_front());
      cred--;
    end
    if (iss) begin
      e.avail = cyc + LATENCY + 1;
      if (s_b == 0) begin
        e.q = 8'hFF; e.r = 8'h00; e.dz = 1'b1;
      end else begin
        e.q = s_a / s_b; e.r = s_a % s_b; e.dz = 1'b0;
      end
      mq.push_back(e);
      cred++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 40 && mq.size() > 0; k++) begin
      predict();
      adv();
    end
    checks++;
    if (mq.size() != 0) begin
      errors++; $display("FAIL drain_timeout left=%0d exp=0", mq.size());
    end
    predict();
    checks++;
    if (occupancy !== 3'd0) begin
      errors++; $display("FAIL drain_occupancy got=%0d exp=0", occupancy);
    end
    adv();
  endtask

  task automatic test_reset();
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%0b exp=0", m_valid); end
    checks++;
    if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%0b exp=1", s_ready); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err); end
    checks++;
    if ({m_dz, m_q, m_r} !== 17'd0) begin errors++; $display("FAIL rst_m_data got=%0h exp=0", {m_dz, m_q, m_r}); end
  endtask

  task automatic test_single();
    int first = -1;
    m_ready = 1'b1;
    s_valid = 1'b1; s_a = 8'd100; s_b = 8'd7;
    predict();
    checks++;
    if ({div_i_valid, div_a, div_b} !== {1'b1, 8'd100, 8'd7}) begin
      errors++; $display("FAIL single_issue got=%0h exp=%0h", {div_i_valid, div_a, div_b}, {1'b1, 8'd100, 8'd7});
    end
    adv();
    s_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      predict();
      checks++;
      if (m_valid !== exp_mv) begin errors++; $display("FAIL single_m_valid cyc=%0d got=%0b exp=%0b", k, m_valid, exp_mv); end
      if (m_valid === 1'b1 && first < 0) begin
        first = k;
        checks++;
        if ({m_dz, m_q, m_r} !== {1'b0, 8'd14, 8'd2}) begin
          errors++; $display("FAIL single_data got=%0h exp=%0h", {m_dz, m_q, m_r}, {1'b0, 8'd14, 8'd2});
        end
      end
      adv();
    end
    checks++;
    if (first != LATENCY + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", first, LATENCY + 1); end
    checks++;
    if (occupancy !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL single_end occ=%0d err=%0b exp occ=0 err=0", occupancy, err);
    end
  endtask

  task automatic test_div_zero();
    bit got = 0;
    m_ready = 1'b1;
    s_valid = 1'b1; s_a = 8'd50; s_b = 8'd0;
    predict(); adv();
    s_valid = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      predict();
      if (m_valid === 1'b1) begin
        got = 1;
        checks++;
        if ({m_dz, m_q, m_r} !== {1'b1, 8'hFF, 8'h00}) begin
          errors++; $display("FAIL dz_data got=%0h exp=%0h", {m_dz, m_q, m_r}, {1'b1, 8'hFF, 8'h00});
        end
      end
      adv();
    end
    checks++;
    if (!got) begin errors++; $display("FAIL dz_timeout got=0 exp=1"); end
  endtask

  task automatic test_backpressure();
    int exp_seq [6] = '{3, 3, 4, 4, 4, 5};
    int got = 0;
    int next_a = 14;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_a = DW'(10 + i); s_b = 8'd3;
      predict();
      checks++;
      if (s_ready !== (i < 4)) begin errors++; $display("FAIL bp_s_ready i=%0d got=%0b exp=%0b", i, s_ready, (i < 4)); end
      adv();
    end
    s_valid = 1'b0;
    predict();
    checks++;
    if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy got=%0d exp=4", occupancy); end
    adv();
    m_ready = 1'b1;
    for (int k = 0; k < 80 && got < 6; k++) begin
      s_valid = (next_a <= 15);
      s_a = DW'(next_a); s_b = 8'd3;
      predict();
      checks++;
      if (m_valid !== exp_mv) begin errors++; $display("FAIL bp_m_valid got=%0b exp=%0b", m_valid, exp_mv); end
      if (exp_mv) begin
        checks++;
        if (m_q !== front.q || m_q !== DW'(exp_seq[got])) begin
          errors++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", got, m_q, exp_seq[got]);
        end
        got++;
      end
      if (s_valid && exp_sr) next_a++;
      adv();
    end
    checks++;
    if (got != 6 || err !== 1'b0) begin errors++; $display("FAIL bp_done got=%0d err=%0b exp 6 err=0", got, err); end
    drain();
  endtask

  task automatic test_full_pop();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_a = DW'(200 + i); s_b = 8'd9;
      predict(); adv();
    end
    s_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      predict();
      if (exp_mv) break;
      adv();
    end
    m_ready = 1'b1; s_valid = 1'b1; s_a = 8'd77; s_b = 8'd5;
    #1;
    checks++;
    if ({s_ready, occupancy, m_valid} !== {1'b0, 3'd4, 1'b1}) begin
      errors++; $display("FAIL fp_full got=%0h exp=%0h", {s_ready, occupancy, m_valid}, {1'b0, 3'd4, 1'b1});
    end
    adv();
    m_ready = 1'b0;
    predict();
    checks++;
    if ({s_ready, occupancy} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL fp_after_pop got=%0h exp=%0h", {s_ready, occupancy}, {1'b1, 3'd3});
    end
    adv();
    s_valid = 1'b0;
    predict();
    checks++;
    if (occupancy !== 3'd4) begin errors++; $display("FAIL fp_refill got=%0d exp=4", occupancy); end
    adv();
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_a     = DW'($urandom_range(0, 255));
      s_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : DW'($urandom_range(1, 255));
      m_ready = ($urandom_range(0, 3) != 0);
      predict();
      checks++;
      if (s_ready !== exp_sr || div_i_valid !== (s_valid & exp_sr)) begin
        errors++; $display("FAIL rnd_ready k=%0d got=%0b/%0b exp=%0b", k, s_ready, div_i_valid, exp_sr);
      end
      checks++;
      if (m_valid !== exp_mv || occupancy !== 3'(cred)) begin
        errors++; $display("FAIL rnd_state k=%0d got mv=%0b occ=%0d exp mv=%0b occ=%0d", k, m_valid, occupancy, exp_mv, cred);
      end
      checks++;
      if (exp_mv) begin
        if ({m_dz, m_q, m_r} !== {front.dz, front.q, front.r}) begin
          errors++; $display("FAIL rnd_data k=%0d got=%0h exp=%0h", k, {m_dz, m_q, m_r}, {front.dz, front.q, front.r});
        end
      end else if ({m_dz, m_q, m_r} !== 17'd0) begin
        errors++; $display("FAIL rnd_idle_data k=%0d got=%0h exp=0", k, {m_dz, m_q, m_r});
      end
      adv();
    end
    drain();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rnd_err got=%0b exp=0", err); end
  endtask

  task automatic test_reset_midflight();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_a = DW'(90 + i); s_b = 8'd4;
      predict(); adv();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin predict(); adv(); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, occupancy, s_ready} !== {1'b0, 3'd0, 1'b1}) begin
      errors++; $display("FAIL mrst_async got=%0h exp=%0h", {m_valid, occupancy, s_ready}, {1'b0, 3'd0, 1'b1});
    end
    mq.delete();
    cred = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < LATENCY + 2; k++) begin
      predict();
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL mrst_stale k=%0d got=%0b exp=0", k, m_valid); end
      adv();
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL mrst_err got=%0b exp=0", err); end
  endtask

  task automatic test_force_err();
    s_valid  = 1'b0;
    force_ov = 1'b1;
    @(posedge clk);
    #1 force_ov = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ferr_set got=%0b exp=1", err); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL ferr_sticky k=%0d got=%0b exp=1", k, err); end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({err, m_valid} !== 2'b00) begin errors++; $display("FAIL ferr_clear got=%0b exp=00", {err, m_valid}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0; force_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single();
    test_div_zero();
    test_backpressure();
    test_full_pop();
    test_random();
    test_reset_midflight();
    test_force_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_flow_ctrl.md
Name: div_flow_ctrl

Overview:
- Flow-control wrapper placed directly around array_divider.
- Accepts dividend/divisor requests on a valid/ready slave port and issues them to the divider's fixed-latency i_valid/A/B inputs.
- Captures divider o_valid/Q_out/R_out into a result FIFO and presents results on a valid/ready master port.
- Credit counting guarantees the FIFO never overflows, since the divider has no backpressure. Divide-by-zero is flagged alongside each result.

Parameters:
DATAWIDTH, 8, operand/result width; must match the divider instance.
LATENCY, 9, divider cycles from i_valid to o_valid; equals the divider's NUM_PIPELINE_STAGES; must be >= 1.
DEPTH, 4, result FIFO entries and maximum outstanding requests; power of two, >= 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  request valid
s_ready  out  1  request accepted when s_valid & s_ready
s_a  in  DATAWIDTH  dividend
s_b  in  DATAWIDTH  divisor
div_i_valid  out  1  to divider i_valid
div_a  out  DATAWIDTH  to divider A
div_b  out  DATAWIDTH  to divider B
div_o_valid  in  1  from divider o_valid
div_q  in  DATAWIDTH  from divider Q_out
div_r  in  DATAWIDTH  from divider R_out
m_valid  out  1  result valid
m_ready  in  1  result consumed when m_valid & m_ready
m_q  out  DATAWIDTH  quotient
m_r  out  DATAWIDTH  remainder
m_dz  out  1  divide-by-zero flag for this result
occupancy  out  $clog2(DEPTH)+1  outstanding credits (in flight + stored)
err  out  1  sticky protocol error

Behaviour:
- Reset: asynchronous on rst_n low. Credits, FIFO pointers, shift registers and err all clear to 0. After reset, m_valid=0, occupancy=0, s_ready=1.
- Divider integration: the divider is driven with rst = ~rst_n.
- Credits:
  - s_ready = (credits < DEPTH), a function of registered state only, with no combinational path from m_ready.
  - Issue (s_valid & s_ready): credits +1.
  - Pop (m_valid & m_ready): credits -1.
  - Issue and pop in the same cycle: credits unchanged.
  - At credits==DEPTH, s_ready=0 even if a pop occurs that cycle.
- Issue path:
  - div_i_valid = s_valid & s_ready.
  - div_a = s_a, div_b = s_b, combinational passthrough.
  - The divider's first enabled stage registers them.
- Alignment tracking: two LATENCY-deep shift registers.
  - exp_v shifts in each issue.
  - dz shifts in issue & (s_b == 0).
  - Both taps align with div_o_valid.
- Push into the FIFO on div_o_valid. The stored entry is {dz_tap, q, r}.
  - dz_tap=1: store q = all ones, r = 0, regardless of divider output.
- FIFO:
  - Read/write pointers are $clog2(DEPTH)+1 bits; the extra bit is the wrap bit.
  - Empty when the pointers are equal; full when the index bits are equal and the wrap bits differ.
  - Push and pop in the same cycle are both performed.
  - Output is first-word-fall-through: m_valid = !empty, and m_q/m_r/m_dz come from the read-pointer entry.
  - When m_valid=0, m_q, m_r and m_dz are 0.
- Ordering: results leave in issue order. Latency from issue to m_valid is LATENCY+1 cycles when the FIFO is empty (one cycle of FIFO write).
- err is set, and remains set until reset, on any of:
  - div_o_valid != exp_v tap;
  - push while full (data dropped);
  - credits would underflow.
- Reset mid-operation: in-flight requests and stored results are discarded. No stale result appears after rst_n deasserts, because the divider is reset and exp_v is cleared.
- occupancy = credits, ranging 0..DEPTH.

Decomposition:
- Package div_pkg:
  - div_result_t packed struct {logic dz; logic [DATAWIDTH-1:0] q, r;} with DATAWIDTH as a package localparam default.
  - Pointer-width constant function based on $clog2.
- One sub-module, div_result_fifo: parameterised on WIDTH and DEPTH, with push/pop/full/empty and first-word-fall-through read.
- Credit counter and shift registers stay in the top.

Test Plan:
Benches use DATAWIDTH=8, LATENCY=9, DEPTH=4, with a real array_divider (FRAC_BITS=0, NUM_PIPELINE_STAGES=9).
- Single request a=100, b=7, m_ready=1 -> m_valid pulses 10 cycles after issue with m_q=14, m_r=2, m_dz=0; occupancy returns to 0; err=0.
- Request a=50, b=0 -> m_q=0xFF, m_r=0, m_dz=1.
- m_ready=0; six back-to-back requests (a=10..15, b=3) -> exactly 4 accepted, s_ready=0 from the 5th cycle, occupancy=4. Release m_ready -> outputs q=3,3,4,4 in order; remaining requests accepted as credits free; no err.
- Credits full with m_ready=1 and s_valid=1 in the same cycle -> pop occurs, no issue that cycle, s_ready=1 on the next cycle, occupancy 4 -> 3 -> 4.
- Three requests in flight, pull rst_n low for 2 cycles mid-flight -> m_valid=0, occupancy=0 immediately. No m_valid for LATENCY+2 cycles after release. err=0.
- Force div_o_valid=1 with no prior issue -> err=1 next cycle and remains 1 until reset.
